spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clkgen.sv | 33 +++
 rtl/spi_master.sv | 144 ++++++++++++++
 tb/tb_spi_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI master slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: spi_state_t (IDLE/LEAD/XFER/TRAIL), DEF_DATA_W, DEF_CLK_DIV.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 5;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator for the SPI serial clock.
// Latency: tick fires on the CLK_DIV-th enabled cycle after a clear, then every CLK_DIV cycles.
// Backpressure: none; counting freezes while en is low.
// Ports: clk, reset (async, active-high), en (count enable), clr (restart count), tick (half-period end).
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: serialises one DATA_W word MSB first, optional MISO capture (macro SPI_RX_EN).
// Latency: busy for CLK_DIV*(2*DATA_W+2) cycles after acceptance; done_send on the next cycle.
// Backpressure: load_data is accepted only in IDLE (including the done_send cycle), ignored otherwise.
// Ports: clk, reset (async, active-high), data_in/load_data (request), busy, done_send, data_out,
//        spi_clk, spi_data (MOSI), spi_miso, spi_cs_n.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_data,
  output logic              busy,
  output logic              done_send,
  output logic [DATA_W-1:0] data_out,
  output logic              spi_clk,
  output logic              spi_data,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int BW = $clog2(DATA_W + 1);

  spi_state_t        state, state_nxt;
  logic              tick;
  logic              accept;
  logic              lead_edge;
  logic              last_edge;
  logic              sclk_q;
  logic              mosi_q;
  logic              done_q;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sh;

  assign accept    = (state == IDLE) && load_data;
  // sclk_q still at its idle level means the coming tick is a leading edge.
  assign lead_edge = (sclk_q == CPOL);
  assign last_edge = !lead_edge && (bit_cnt == BW'(DATA_W - 1));

  spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk  (clk),
    .reset(reset),
    .en   (state != IDLE),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_data)         state_nxt = LEAD;
      LEAD:    if (tick)              state_nxt = XFER;
      XFER:    if (tick && last_edge) state_nxt = TRAIL;
      TRAIL:   if (tick)              state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    spi_cs_n = (state == IDLE);
    spi_clk  = (state == XFER) ? sclk_q : CPOL;
    spi_data = (state == IDLE) ? 1'b1 : mosi_q;
  end

  assign done_send = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q  <= CPOL;
      mosi_q  <= 1'b1;
      done_q  <= 1'b0;
      bit_cnt <= '0;
      tx_sh   <= '0;
    end else begin
      done_q <= (state == TRAIL) && tick;
      if (accept) begin
        sclk_q  <= CPOL;
        bit_cnt <= '0;
        if (CPHA) begin
          // First bit goes out on the first leading edge; line stays high until then.
          mosi_q <= 1'b1;
          tx_sh  <= data_in;
        end else begin
          // MSB must already be on the line during LEAD.
          mosi_q <= data_in[DATA_W-1];
          tx_sh  <= {data_in[DATA_W-2:0], 1'b0};
        end
      end else if ((state == XFER) && tick) begin
        sclk_q <= ~sclk_q;
        // CPHA=1 drives on leading edges, CPHA=0 on trailing edges.
        if (lead_edge == CPHA) begin
          mosi_q <= tx_sh[DATA_W-1];
          tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
        end
        if (!lead_edge) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPI_RX_EN
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sh   <= '0;
      rx_word <= '0;
    end else begin
      // Sampling edge is the opposite of the driving edge.
      if ((state == XFER) && tick && (lead_edge != CPHA)) begin
        rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
      end
      if ((state == TRAIL) && tick) begin
        rx_word <= rx_sh;
      end
    end
  end

  assign data_out = rx_word;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign data_out    = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: four CPOL/CPHA instances (8-bit, CLK_DIV=5) with MISO looped
// to MOSI, plus a 16-bit CLK_DIV=1 instance for back-to-back frames.
module tb_spi_master;

`ifdef SPI_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] ld;
  logic [7:0] din [4];
  wire  [3:0] busy;
  wire  [3:0] done;
  wire  [3:0] sclk;
  wire  [3:0] sdata;
  wire  [3:0] csn;
  wire  [7:0] dout [4];

  logic        ld16;
  logic [15:0] din16;
  wire         busy16, done16, sclk16, sdata16, csn16;
  wire  [15:0] dout16;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_master #(
      .DATA_W (8),
      .CLK_DIV(5),
      .CPOL   ((g / 2) == 1),
      .CPHA   ((g % 2) == 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (din[g]),
      .load_data(ld[g]),
      .busy     (busy[g]),
      .done_send(done[g]),
      .data_out (dout[g]),
      .spi_clk  (sclk[g]),
      .spi_data (sdata[g]),
      .spi_miso (sdata[g]),
      .spi_cs_n (csn[g])
    );
  end

  spi_master #(
    .DATA_W (16),
    .CLK_DIV(1),
    .CPOL   (1'b0),
    .CPHA   (1'b0)
  ) u_dut16 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (din16),
    .load_data(ld16),
    .busy     (busy16),
    .done_send(done16),
    .data_out (dout16),
    .spi_clk  (sclk16),
    .spi_data (sdata16),
    .spi_miso (sdata16),
    .spi_cs_n (csn16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         m;          // instance: bit1 = CPOL, bit0 = CPHA
    logic [7:0] d;
    int         glitch_at;  // frame cycle of a stray load_data pulse, -1 = none
    int         rst_at;     // frame cycle of a reset pulse, -1 = none
    int         exp_busy;   // busy cycles (also spi_cs_n low cycles)
    int         exp_lead;   // leading spi_clk edges
    logic [7:0] exp_bits;   // MOSI bits seen on sampling edges, MSB first
    int         exp_done;
    logic [7:0] exp_rx;     // data_out at done_send when receive is built in
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int         busy_n, cs_low, lead_n, done_n;
    logic [7:0] bits, rx_seen;
    logic       cpol, cpha, prev;
    busy_n = 0; cs_low = 0; lead_n = 0; done_n = 0;
    bits = 8'h00; rx_seen = 8'h00;
    cpol = (v.m / 2) == 1;
    cpha = (v.m % 2) == 1;
    prev = cpol;
    @(negedge clk);
    din[v.m] = v.d;
    ld[v.m]  = 1'b1;
    @(posedge clk);
    #1 ld[v.m] = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (cyc == v.glitch_at) begin
        ld[v.m]  = 1'b1;
        din[v.m] = ~v.d;
      end
      if (cyc == v.glitch_at + 1) ld[v.m] = 1'b0;
      if (cyc == v.rst_at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("v%0d rst busy", idx), busy[v.m], 0);
        chk($sformatf("v%0d rst done", idx), done[v.m], 0);
        chk($sformatf("v%0d rst sclk", idx), sclk[v.m], cpol);
        chk($sformatf("v%0d rst sdata", idx), sdata[v.m], 1);
        chk($sformatf("v%0d rst csn", idx), csn[v.m], 1);
        chk($sformatf("v%0d rst dout", idx), dout[v.m], 0);
      end
      if (cyc == v.rst_at + 1) reset = 1'b0;
      if (busy[v.m]) busy_n++;
      if (!csn[v.m]) cs_low++;
      if (done[v.m]) begin
        done_n++;
        rx_seen = dout[v.m];
      end
      if (sclk[v.m] != prev) begin
        if (sclk[v.m] != cpol) begin
          lead_n++;
          if (!cpha) bits = {bits[6:0], sdata[v.m]};
        end else if (cpha) begin
          bits = {bits[6:0], sdata[v.m]};
        end
        prev = sclk[v.m];
      end
    end
    chk($sformatf("v%0d busy cycles", idx), busy_n, v.exp_busy);
    chk($sformatf("v%0d cs low cycles", idx), cs_low, v.exp_busy);
    chk($sformatf("v%0d leading edges", idx), lead_n, v.exp_lead);
    chk($sformatf("v%0d mosi bits", idx), bits, v.exp_bits);
    chk($sformatf("v%0d done pulses", idx), done_n, v.exp_done);
    chk($sformatf("v%0d data_out", idx), rx_seen, RX_EN ? v.exp_rx : 8'h00);
    chk($sformatf("v%0d idle sclk", idx), sclk[v.m], cpol);
    chk($sformatf("v%0d idle sdata", idx), sdata[v.m], 1);
    chk($sformatf("v%0d idle csn", idx), csn[v.m], 1);
  endtask

  initial begin
    int          busy_n, csn_hi, done_n, lead_n;
    logic [15:0] bits16;
    logic        prev16;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    ld = 4'b0000;
    ld16 = 1'b0;
    din16 = 16'h0000;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    //           m  d      glt  rst busy lead bits   done rx
    vecs[0] = '{0, 8'hA5, -1, -1, 90, 8, 8'hA5, 1, 8'hA5};
    vecs[1] = '{0, 8'h3C, -1, -1, 90, 8, 8'h3C, 1, 8'h3C};
    vecs[2] = '{1, 8'h3C, -1, -1, 90, 8, 8'h3C, 1, 8'h3C};
    vecs[3] = '{2, 8'h3C, -1, -1, 90, 8, 8'h3C, 1, 8'h3C};
    vecs[4] = '{3, 8'h3C, -1, -1, 90, 8, 8'h3C, 1, 8'h3C};
    vecs[5] = '{3, 8'hFF, -1, -1, 90, 8, 8'hFF, 1, 8'hFF};
    vecs[6] = '{0, 8'hA5, 20, -1, 90, 8, 8'hA5, 1, 8'hA5};
    vecs[7] = '{0, 8'hA5, -1, 40, 40, 3, 8'h05, 0, 8'h00};
    vecs[8] = '{0, 8'h5A, -1, -1, 90, 8, 8'h5A, 1, 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("reset m%0d busy", m), busy[m], 0);
      chk($sformatf("reset m%0d done", m), done[m], 0);
      chk($sformatf("reset m%0d sclk", m), sclk[m], (m / 2) == 1);
      chk($sformatf("reset m%0d sdata", m), sdata[m], 1);
      chk($sformatf("reset m%0d csn", m), csn[m], 1);
      chk($sformatf("reset m%0d dout", m), dout[m], 0);
    end
    chk("reset w16 csn", csn16, 1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // 16-bit, CLK_DIV=1, load_data held: 34 busy cycles then one idle cycle per frame.
    busy_n = 0; csn_hi = 0; done_n = 0; lead_n = 0;
    bits16 = 16'h0000;
    prev16 = 1'b0;
    @(negedge clk);
    din16 = 16'h8001;
    ld16 = 1'b1;
    for (int cyc = 0; cyc < 105; cyc++) begin
      @(negedge clk);
      if (busy16) busy_n++;
      if (csn16) csn_hi++;
      if (done16) done_n++;
      if (sclk16 != prev16) begin
        if (sclk16) begin
          lead_n++;
          if (lead_n <= 16) bits16 = {bits16[14:0], sdata16};
        end
        prev16 = sclk16;
      end
      if (cyc == 33 || cyc == 35) chk($sformatf("w16 csn c%0d", cyc), csn16, 0);
      if (cyc == 34 || cyc == 69) begin
        chk($sformatf("w16 csn c%0d", cyc), csn16, 1);
        chk($sformatf("w16 done c%0d", cyc), done16, 1);
      end
    end
    ld16 = 1'b0;
    chk("w16 busy cycles", busy_n, 102);
    chk("w16 csn high cycles", csn_hi, 3);
    chk("w16 done pulses", done_n, 3);
    chk("w16 leading edges", lead_n, 48);
    chk("w16 mosi bits", bits16, 16'h8001);
    repeat (3) @(negedge clk);
    chk("w16 idle busy", busy16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
